// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch slice:
//   - fetch FSM state encoding
//   - instruction field widths
//   - opcode constants used by downstream decode/control
//   - sequential PC advance helper
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    // Sequential next PC; the add is modulo 2^32 so the top word wraps to 0.
    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/instr_fields.sv
// ----------------------------------------------------------------------------
// instr_fields
// Purely combinational slicing of a 32-bit instruction word into its fields.
// Ports:
//   instr_i   [31:0]  instruction word (from the instruction register)
//   opcode_o  [5:0]   instr[31:26]
//   rs_o      [4:0]   instr[25:21]
//   rt_o      [4:0]   instr[20:16]
//   rd_o      [4:0]   instr[15:11]
//   shamt_o   [4:0]   instr[10:6]
//   funct_o   [5:0]   instr[5:0]
//   imm_o     [15:0]  instr[15:0]
// ----------------------------------------------------------------------------
module instr_fields
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0]     instr_i,
    output logic [OPCODE_W-1:0] opcode_o,
    output logic [REG_W-1:0]    rs_o,
    output logic [REG_W-1:0]    rt_o,
    output logic [REG_W-1:0]    rd_o,
    output logic [REG_W-1:0]    shamt_o,
    output logic [FUNCT_W-1:0]  funct_o,
    output logic [IMM_W-1:0]    imm_o
);

    assign opcode_o = instr_i[31:26];
    assign rs_o     = instr_i[25:21];
    assign rt_o     = instr_i[20:16];
    assign rd_o     = instr_i[15:11];
    assign shamt_o  = instr_i[10:6];
    assign funct_o  = instr_i[5:0];
    assign imm_o    = instr_i[15:0];

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Single-outstanding-request instruction fetcher. Issues a read at the fetch
// PC, latches the returned word into the instruction register, presents its
// decoded fields until the decoder accepts it, then fetches the next word.
// A redirect reloads the fetch PC and squashes whatever is in flight or held.
// Parameters:
//   RESET_PC       first fetch address after reset
//   PC_STEP        byte increment per sequential fetch
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   en_i           fetch enable
//   stall_i        downstream not accepting the held instruction
//   redirect_i     branch/jump redirect strobe (highest priority)
//   redirect_pc_i  redirect target, used as given
//   imem_req_o     instruction memory read request
//   imem_addr_o    read address (the fetch PC)
//   imem_ack_i     read data valid
//   imem_data_i    instruction word
//   pc_o           address of the held instruction
//   instr_valid_o  held instruction / decoded fields valid
//   opcode_o .. imm_o  fields of the held instruction
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                imem_req_o,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [XLEN-1:0]     imem_data_i,
    output logic [XLEN-1:0]     pc_o,
    output logic                instr_valid_o,
    output logic [OPCODE_W-1:0] opcode_o,
    output logic [REG_W-1:0]    rs_o,
    output logic [REG_W-1:0]    rt_o,
    output logic [REG_W-1:0]    rd_o,
    output logic [REG_W-1:0]    shamt_o,
    output logic [FUNCT_W-1:0]  funct_o,
    output logic [IMM_W-1:0]    imm_o
);

    fetch_state_e    state_r;
    fetch_state_e    next_state_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] instr_r;
    logic            req_r;
    logic            valid_r;
    logic            latch_s;
    logic            load_redirect_s;

    // Next-state and datapath-control decode; a redirect outranks every other event.
    always_comb begin
        next_state_s    = state_r;
        latch_s         = 1'b0;
        load_redirect_s = 1'b0;
        if (redirect_i) begin
            // Same-cycle ack data is dropped simply by not asserting latch_s.
            load_redirect_s = 1'b1;
            if (en_i) begin
                next_state_s = ST_REQ;
            end else begin
                next_state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en_i) begin
                        next_state_s = ST_REQ;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // en_i is deliberately not looked at: an issued request always completes.
                    if (imem_ack_i) begin
                        latch_s      = 1'b1;
                        next_state_s = ST_HOLD;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (stall_i) begin
                        next_state_s = ST_HOLD;
                    end else if (en_i) begin
                        next_state_s = ST_REQ;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fetch PC: redirect target, or sequential advance once a fetch is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_r <= RESET_PC;
        end else if (load_redirect_s) begin
            fetch_pc_r <= redirect_pc_i;
        end else if (latch_s) begin
            fetch_pc_r <= pc_advance(fetch_pc_r, PC_STEP);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Instruction register and its address, written only when a fetch is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_r <= 32'h0000_0000;
            pc_r    <= RESET_PC;
        end else if (latch_s) begin
            instr_r <= imem_data_i;
            pc_r    <= fetch_pc_r;
        end else begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
        end
    end

    // Request and valid flags registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            req_r   <= (next_state_s == ST_REQ);
            valid_r <= (next_state_s == ST_HOLD);
        end
    end

    assign imem_req_o    = req_r;
    assign imem_addr_o   = fetch_pc_r;
    assign pc_o          = pc_r;
    assign instr_valid_o = valid_r;

    instr_fields u_fields (
        .instr_i  (instr_r),
        .opcode_o (opcode_o),
        .rs_o     (rs_o),
        .rt_o     (rt_o),
        .rd_o     (rd_o),
        .shamt_o  (shamt_o),
        .funct_o  (funct_o),
        .imm_o    (imm_o)
    );

endmodule
